// File: rtl/mem_bus_arbiter_if.sv
// Core-side and memory-side bus bundle for mem_bus_arbiter.
// The arbiter owns the master view: it takes IFU/LSU requests, issues the single
// memory request, and routes memory responses back. The slave view is the
// environment (core ports plus memory) that the arbiter talks to.
interface mem_bus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // Handshake rule for every req/rsp channel below: a transfer happens on a rising
   // clock edge where valid and ready are both 1; once valid is raised, the sender
   // holds valid and its payload stable until that edge.
   logic            ifu_req_valid;
   logic            ifu_req_ready;
   logic [AW-1:0]   ifu_req_addr;
   logic            ifu_rsp_valid;
   logic            ifu_rsp_ready;
   logic [DW-1:0]   ifu_rsp_rdata;
   logic            ifu_rsp_err;

   logic            lsu_req_valid;
   logic            lsu_req_ready;
   logic [AW-1:0]   lsu_req_addr;
   logic            lsu_req_wen;
   logic [DW-1:0]   lsu_req_wdata;
   logic [DW/8-1:0] lsu_req_wmask;
   logic            lsu_rsp_valid;
   logic            lsu_rsp_ready;
   logic [DW-1:0]   lsu_rsp_rdata;
   logic            lsu_rsp_err;

   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [AW-1:0]   mem_req_addr;
   logic            mem_req_wen;
   logic [DW-1:0]   mem_req_wdata;
   logic [DW/8-1:0] mem_req_wmask;
   logic            mem_rsp_valid;
   logic            mem_rsp_ready;
   logic [DW-1:0]   mem_rsp_rdata;
   logic            mem_rsp_err;

   // arbiter side
   modport master (
      input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
      input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_rsp_ready,
      output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
      output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_rsp_ready,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
   );

   // core + memory side
   modport slave (
      output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
      output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_rsp_ready,
      input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
      input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_rsp_ready,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the IFU fetch port and the LSU data port.
// Round-robin arbitration, one outstanding transaction, responses routed to the
// owner. A silent memory produces an error response after TIMEOUT cycles and the
// late response is then drained so the bus stays in step.
module mem_bus_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   mem_bus_arbiter_if.master bus,
   output logic [2:0]        dbg_state_o
);
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOCK     = 3'd1,
      S_WAIT_RSP = 3'd2,
      S_ERR_RSP  = 3'd3,
      S_DRAIN    = 3'd4
   } state_e;

   typedef enum logic {
      SRC_IFU = 1'b0,
      SRC_LSU = 1'b1
   } src_e;

   // counter only needs to reach TIMEOUT-1
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   state_e          state_q, state_d;
   src_e            owner_q, owner_d;
   src_e            rr_last_q, rr_last_d;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

   src_e            winner;
   src_e            sel;
   logic            sel_valid;
   logic            req_phase;
   logic            req_valid;
   logic            req_hs;
   logic            own_rsp_ready;
   logic            rsp_fwd;
   logic            err_phase;
   logic            req_out;
   logic            rsp_out;
   logic            rsp_err;
   logic [DW-1:0]   rsp_rdata;
   logic [AW-1:0]   sel_addr;

   // fresh arbitration: a lone requester wins, a tie goes to the side not granted last
   always_comb begin
      winner = SRC_IFU;
      if (bus.lsu_req_valid && (!bus.ifu_req_valid || rr_last_q == SRC_IFU))
         winner = SRC_LSU;
   end

   // In LOCK the grant is frozen to the owner; in IDLE it follows the live winner.
   assign req_phase     = (state_q == S_IDLE) || (state_q == S_LOCK);
   assign sel           = (state_q == S_LOCK) ? owner_q : winner;
   assign sel_valid     = (sel == SRC_IFU) ? bus.ifu_req_valid : bus.lsu_req_valid;
   assign req_valid     = req_phase && sel_valid;
   assign req_hs        = req_valid && bus.mem_req_ready;
   assign own_rsp_ready = (owner_q == SRC_IFU) ? bus.ifu_rsp_ready : bus.lsu_rsp_ready;
   assign rsp_fwd       = (state_q == S_WAIT_RSP) && bus.mem_rsp_valid;
   assign err_phase     = (state_q == S_ERR_RSP);
   assign sel_addr      = (sel == SRC_IFU) ? bus.ifu_req_addr : bus.lsu_req_addr;

   // Outputs are gated by rst so every valid/ready drops the moment reset asserts,
   // even while requesters keep their valids high. Next-state logic uses the
   // ungated terms so rst only ever acts as an asynchronous reset on the flops.
   assign req_out           = rst && req_valid;
   assign bus.mem_req_valid = req_out;
   assign bus.mem_req_addr  = req_out ? sel_addr : '0;
   assign bus.mem_req_wen   = req_out && (sel == SRC_LSU) && bus.lsu_req_wen;
   assign bus.mem_req_wdata = (req_out && sel == SRC_LSU) ? bus.lsu_req_wdata : '0;
   assign bus.mem_req_wmask = !req_out ? '0 : ((sel == SRC_LSU) ? bus.lsu_req_wmask : '1);
   assign bus.ifu_req_ready = req_out && (sel == SRC_IFU) && bus.mem_req_ready;
   assign bus.lsu_req_ready = req_out && (sel == SRC_LSU) && bus.mem_req_ready;

   // Response path: pass-through in WAIT_RSP, synthesized error in ERR_RSP.
   assign rsp_out           = rst && (rsp_fwd || err_phase);
   assign rsp_err           = rst && (err_phase || (rsp_fwd && bus.mem_rsp_err));
   assign rsp_rdata         = (rst && rsp_fwd) ? bus.mem_rsp_rdata : '0;
   assign bus.ifu_rsp_valid = rsp_out && (owner_q == SRC_IFU);
   assign bus.ifu_rsp_err   = rsp_err && (owner_q == SRC_IFU);
   assign bus.ifu_rsp_rdata = (owner_q == SRC_IFU) ? rsp_rdata : '0;
   assign bus.lsu_rsp_valid = rsp_out && (owner_q == SRC_LSU);
   assign bus.lsu_rsp_err   = rsp_err && (owner_q == SRC_LSU);
   assign bus.lsu_rsp_rdata = (owner_q == SRC_LSU) ? rsp_rdata : '0;
   assign bus.mem_rsp_ready = rst && (((state_q == S_WAIT_RSP) && own_rsp_ready) ||
                                      (state_q == S_DRAIN));

   assign dbg_state_o = state_q;

   // next-state and bookkeeping for grant, round-robin pointer and timeout
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_last_d = rr_last_q;
      tmo_cnt_d = tmo_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               owner_d = winner;
               if (bus.mem_req_ready) begin
                  rr_last_d = winner;
                  tmo_cnt_d = '0;
                  state_d   = S_WAIT_RSP;
               end else begin
                  state_d = S_LOCK;
               end
            end
         end
         S_LOCK: begin
            if (req_hs) begin
               rr_last_d = owner_q;
               tmo_cnt_d = '0;
               state_d   = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            // a response on the limit cycle wins over the timeout
            if (bus.mem_rsp_valid) begin
               if (own_rsp_ready) state_d = S_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
               if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) state_d = S_ERR_RSP;
            end
         end
         S_ERR_RSP: begin
            if (own_rsp_ready) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // swallow the late memory response without forwarding it
            if (bus.mem_rsp_valid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state registers; IFU wins the first tie after reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         owner_q   <= SRC_IFU;
         rr_last_q <= SRC_LSU;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level reference model that
// is checked against every output on every falling clock edge.
module tb_mem_bus_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] dbg_state;
   int         n_vec  = 0;
   int         n_fail = 0;
   bit         model_on = 1'b0;

   mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks transactions, not arbiter states: who holds an untaken grant, whose
   // response is outstanding, how long memory has been silent, and whether an
   // error reply or a drain is still owed.
   int m_last;     // side granted most recently: 0 IFU, 1 LSU
   int m_pend;     // side whose grant memory has not yet taken, -1 none
   int m_txn;      // side with an outstanding response, -1 none
   int m_silent;
   bit m_err_owed;
   bit m_drain;

   int          cand;
   logic        e_mreq_v, e_ifu_rdy, e_lsu_rdy, e_mrsp_rdy;
   logic        e_rsp_v, e_rsp_err;
   logic [31:0] e_rsp_rd, e_addr, e_wdata;
   logic        e_wen;
   logic [3:0]  e_wmask;
   int          e_rsp_side;
   logic        own_rdy;

   initial begin
      forever begin
         @(negedge clk);
         e_mreq_v = 0; e_ifu_rdy = 0; e_lsu_rdy = 0; e_mrsp_rdy = 0;
         e_rsp_v = 0; e_rsp_err = 0; e_rsp_rd = '0; e_rsp_side = -1;
         e_addr = '0; e_wdata = '0; e_wen = 0; e_wmask = '0;
         if (!rst) begin
            m_last = 1; m_pend = -1; m_txn = -1; m_silent = 0;
            m_err_owed = 0; m_drain = 0;
         end else if (m_txn < 0 && !m_drain) begin
            if (m_pend >= 0) cand = m_pend;
            else if (bus.ifu_req_valid && bus.lsu_req_valid) cand = 1 - m_last;
            else if (bus.ifu_req_valid) cand = 0;
            else if (bus.lsu_req_valid) cand = 1;
            else cand = -1;
            if (cand == 0 && bus.ifu_req_valid) begin
               e_mreq_v = 1; e_addr = bus.ifu_req_addr; e_wmask = 4'hF;
            end else if (cand == 1 && bus.lsu_req_valid) begin
               e_mreq_v = 1; e_addr = bus.lsu_req_addr; e_wen = bus.lsu_req_wen;
               e_wdata = bus.lsu_req_wdata; e_wmask = bus.lsu_req_wmask;
            end
            e_ifu_rdy = e_mreq_v && cand == 0 && bus.mem_req_ready;
            e_lsu_rdy = e_mreq_v && cand == 1 && bus.mem_req_ready;
            if (e_mreq_v && bus.mem_req_ready) begin
               m_txn = cand; m_last = cand; m_pend = -1; m_silent = 0;
            end else if (e_mreq_v) begin
               m_pend = cand;
            end
         end else if (m_drain) begin
            e_mrsp_rdy = 1;
            if (bus.mem_rsp_valid) m_drain = 0;
         end else begin
            own_rdy = (m_txn == 0) ? bus.ifu_rsp_ready : bus.lsu_rsp_ready;
            e_rsp_side = m_txn;
            if (m_err_owed) begin
               e_rsp_v = 1; e_rsp_err = 1;
               if (own_rdy) begin
                  m_err_owed = 0; m_txn = -1; m_drain = 1;
               end
            end else begin
               e_rsp_v = bus.mem_rsp_valid;
               e_rsp_rd = bus.mem_rsp_valid ? bus.mem_rsp_rdata : '0;
               e_rsp_err = bus.mem_rsp_valid && bus.mem_rsp_err;
               e_mrsp_rdy = own_rdy;
               if (bus.mem_rsp_valid) begin
                  if (own_rdy) m_txn = -1;
               end else begin
                  m_silent++;
                  if (m_silent == TMO) m_err_owed = 1;
               end
            end
         end
         if (model_on) begin
            chk("ifu_req_ready", bus.ifu_req_ready, e_ifu_rdy);
            chk("lsu_req_ready", bus.lsu_req_ready, e_lsu_rdy);
            chk("mem_req_valid", bus.mem_req_valid, e_mreq_v);
            chk("mem_rsp_ready", bus.mem_rsp_ready, e_mrsp_rdy);
            if (e_mreq_v) begin
               chk("mem_req_addr", bus.mem_req_addr, e_addr);
               chk("mem_req_wen", bus.mem_req_wen, e_wen);
               chk("mem_req_wdata", bus.mem_req_wdata, e_wdata);
               chk("mem_req_wmask", bus.mem_req_wmask, e_wmask);
            end
            chk("ifu_rsp_valid", bus.ifu_rsp_valid, e_rsp_side == 0 && e_rsp_v);
            chk("ifu_rsp_rdata", bus.ifu_rsp_rdata, (e_rsp_side == 0) ? e_rsp_rd : 32'h0);
            chk("ifu_rsp_err", bus.ifu_rsp_err, e_rsp_side == 0 && e_rsp_err);
            chk("lsu_rsp_valid", bus.lsu_rsp_valid, e_rsp_side == 1 && e_rsp_v);
            chk("lsu_rsp_rdata", bus.lsu_rsp_rdata, (e_rsp_side == 1) ? e_rsp_rd : 32'h0);
            chk("lsu_rsp_err", bus.lsu_rsp_err, e_rsp_side == 1 && e_rsp_err);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.ifu_req_valid = 0; bus.ifu_req_addr = '0; bus.ifu_rsp_ready = 1;
      bus.lsu_req_valid = 0; bus.lsu_req_addr = '0; bus.lsu_req_wen = 0;
      bus.lsu_req_wdata = '0; bus.lsu_req_wmask = '0; bus.lsu_rsp_ready = 1;
      bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = '0;
      bus.mem_rsp_err = 0;
   endtask

   task automatic do_reset();
      step();
      rst = 0;
      clear_inputs();
      step();
      step();
      rst = 1;
   endtask

   // wait for a request handshake, report which side took it; returns just past that edge
   task automatic wait_grant(output int who, output logic wen);
      who = -1;
      wen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.mem_req_valid && bus.mem_req_ready) begin
            who = bus.ifu_req_ready ? 0 : (bus.lsu_req_ready ? 1 : 2);
            wen = bus.mem_req_wen;
            break;
         end
      end
      if (who < 0) chk("grant_timeout", 32'd0, 32'd1);
      step();
   endtask

   // present one memory response and check it reaches the given side intact
   task automatic respond(input int side, input logic [31:0] rd);
      bit ok = 0;
      bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = rd; bus.mem_rsp_err = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.mem_rsp_ready) begin ok = 1; break; end
      end
      chk("rsp_accepted", ok, 1);
      chk("rsp_side_valid", (side == 0) ? bus.ifu_rsp_valid : bus.lsu_rsp_valid, 1);
      chk("rsp_side_rdata", (side == 0) ? bus.ifu_rsp_rdata : bus.lsu_rsp_rdata, rd);
      step();
      bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = '0;
   endtask

   // ---------------- directed stimulus ----------------
   logic [31:0] exp_q[$];
   int          who;
   logic        wen;
   int          silent;
   bit          seen;

   initial begin
      clear_inputs();
      rst = 0;
      model_on = 1;
      @(negedge clk); #1;
      chk("rst_state", dbg_state, 3'd0);
      chk("rst_mem_req_valid", bus.mem_req_valid, 0);
      chk("rst_mem_rsp_ready", bus.mem_rsp_ready, 0);
      step();
      rst = 1;

      // 1: IFU-only read
      bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h8000_0000; bus.mem_req_ready = 1;
      @(negedge clk);
      chk("t1_ifu_ready_same_cycle", bus.ifu_req_ready, 1);
      chk("t1_addr", bus.mem_req_addr, 32'h8000_0000);
      step();
      bus.ifu_req_valid = 0; bus.mem_req_ready = 0;
      respond(0, 32'h0000_0413);
      chk("t1_lsu_quiet", bus.lsu_rsp_valid, 0);

      // 2: repeated ties after reset alternate, IFU first
      do_reset();
      exp_q = {32'd0, 32'd1, 32'd0, 32'd1};
      bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h8000_0040;
      bus.lsu_req_valid = 1; bus.lsu_req_addr = 32'h0000_1000; bus.lsu_req_wen = 1;
      bus.lsu_req_wdata = 32'h0000_0011; bus.lsu_req_wmask = 4'h3;
      bus.mem_req_ready = 1;
      for (int k = 0; k < 4; k++) begin
         wait_grant(who, wen);
         chk("t2_grant_order", who, exp_q[0]);
         chk("t2_wen_follows_lsu", wen, exp_q[0] == 32'd1);
         void'(exp_q.pop_front());
         respond(who, 32'h100 + k);
      end
      bus.ifu_req_valid = 0; bus.lsu_req_valid = 0; bus.mem_req_ready = 0;

      // 3: LSU write held in LOCK while IFU waits
      bus.lsu_req_valid = 1; bus.lsu_req_addr = 32'h0000_2000; bus.lsu_req_wen = 1;
      bus.lsu_req_wdata = 32'hDEAD_BEEF; bus.lsu_req_wmask = 4'hF;
      step();
      bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h8000_0200;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_lock_addr", bus.mem_req_addr, 32'h0000_2000);
         chk("t3_lock_wdata", bus.mem_req_wdata, 32'hDEAD_BEEF);
         chk("t3_lock_wen", bus.mem_req_wen, 1);
         step();
      end
      bus.mem_req_ready = 1;
      wait_grant(who, wen);
      chk("t3_lsu_first", who, 1);
      bus.lsu_req_valid = 0; bus.lsu_req_wen = 0;
      @(negedge clk);
      chk("t3_ifu_waits", bus.ifu_req_ready, 0);
      step();
      respond(1, 32'h0);
      wait_grant(who, wen);
      chk("t3_ifu_after", who, 0);
      bus.ifu_req_valid = 0; bus.mem_req_ready = 0;
      respond(0, 32'h0000_0013);

      // 4: timeout, drain of the late response, then a normal fetch
      bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h8000_0100; bus.mem_req_ready = 1;
      wait_grant(who, wen);
      chk("t4_grant", who, 0);
      bus.ifu_req_valid = 0; bus.mem_req_ready = 0;
      silent = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.ifu_rsp_valid) seen = 1;
         else silent++;
      end
      chk("t4_err_seen", seen, 1);
      chk("t4_wait_cycles", silent, TMO);
      chk("t4_err", bus.ifu_rsp_err, 1);
      chk("t4_err_rdata", bus.ifu_rsp_rdata, 32'h0);
      step();
      bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("t4_drain_ready", bus.mem_rsp_ready, 1);
      chk("t4_drain_not_fwd", bus.ifu_rsp_valid, 0);
      step();
      bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = '0;
      bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h8000_0104; bus.mem_req_ready = 1;
      wait_grant(who, wen);
      chk("t4_next_grant", who, 0);
      bus.ifu_req_valid = 0; bus.mem_req_ready = 0;
      respond(0, 32'h0000_0013);

      // 5: owner back-pressure on the response, longer than the timeout
      bus.lsu_req_valid = 1; bus.lsu_req_addr = 32'h0000_3000; bus.lsu_req_wen = 0;
      bus.mem_req_ready = 1;
      wait_grant(who, wen);
      chk("t5_grant", who, 1);
      bus.lsu_req_valid = 0; bus.mem_req_ready = 0; bus.lsu_rsp_ready = 0;
      bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = 32'h1234_5678;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("t5_mem_rsp_ready", bus.mem_rsp_ready, 0);
         chk("t5_rdata_held", bus.lsu_rsp_rdata, 32'h1234_5678);
         chk("t5_no_err", bus.lsu_rsp_err, 0);
         step();
      end
      bus.lsu_rsp_ready = 1;
      @(negedge clk);
      chk("t5_release", bus.mem_rsp_ready, 1);
      step();
      bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = '0;

      // 6: reset in the middle of an IFU transaction
      bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h8000_0300; bus.mem_req_ready = 1;
      wait_grant(who, wen);
      chk("t6_grant", who, 0);
      bus.lsu_req_valid = 1; bus.lsu_req_addr = 32'h0000_4000;
      bus.ifu_rsp_ready = 0; bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = 32'h55;
      @(negedge clk);
      chk("t6_pre_rsp_valid", bus.ifu_rsp_valid, 1);
      #2;
      rst = 0;
      bus.mem_rsp_valid = 0;
      #1;
      chk("t6_async_rsp_valid", bus.ifu_rsp_valid, 0);
      chk("t6_async_mem_req_valid", bus.mem_req_valid, 0);
      chk("t6_async_ifu_ready", bus.ifu_req_ready, 0);
      chk("t6_async_lsu_ready", bus.lsu_req_ready, 0);
      chk("t6_async_mem_rsp_ready", bus.mem_rsp_ready, 0);
      step();
      step();
      rst = 1;
      bus.ifu_rsp_ready = 1;
      wait_grant(who, wen);
      chk("t6_ifu_first_tie", who, 0);
      bus.ifu_req_valid = 0;
      respond(0, 32'h66);
      wait_grant(who, wen);
      chk("t6_lsu_next", who, 1);
      bus.lsu_req_valid = 0; bus.mem_req_ready = 0;
      respond(1, 32'h77);

      step();
      step();
      model_on = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
